// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared defaults, coordinate widths and capture FSM encoding
//                for the camera pixel capture front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    // Default active window of the sensor (VGA).
    localparam int c_h_active_def = 640;
    localparam int c_v_active_def = 480;

    // Coordinate widths of the pixel tags.
    localparam int c_x_w = 10;
    localparam int c_y_w = 9;

    // Capture control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } cam_state_t;

endpackage
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : cam_sync_edge
//  Description : STAGES-deep synchroniser for one asynchronous camera pin,
//                with registered level and single-clk rise/fall pulses that
//                are aligned to each other.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic res,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    // Synchronise the pin, then register the edge pulses next to the level.
    always_ff @(posedge clk) begin
        if (res) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

    // r_prev is the level that matches the cycle in which a pulse is seen.
    assign level = r_prev;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/cam_pixel_capture.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pixel_capture
//  Description : Camera front end. Synchronises pclk/href/vsync/data into clk,
//                pairs bytes into 16-bit pixels tagged with x/y, and frames an
//                armed capture with frame_start/frame_done strobes.
//                Build option CAM_CONTINUOUS_EN: after frame_done re-arm
//                automatically so capture free-runs until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = c_h_active_def,
    parameter int V_ACTIVE    = c_v_active_def,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             res,
    input  logic             cam_pclk,
    input  logic             cam_href,
    input  logic             cam_vsync,
    input  logic [7:0]       cam_data,
    input  logic             capture,
    output logic             busy,
    output logic             pix_valid,
    output logic [15:0]      pix_data,
    output logic [c_x_w-1:0] pix_x,
    output logic [c_y_w-1:0] pix_y,
    output logic             frame_start,
    output logic             frame_done,
    output logic             line_err
);

    localparam logic [c_x_w-1:0] c_h_lim = H_ACTIVE[c_x_w-1:0];
    localparam logic [c_y_w-1:0] c_v_lim = V_ACTIVE[c_y_w-1:0];

    // Synchronised camera events
    logic w_pclk_lvl, w_pclk_rise, w_pclk_fall;
    logic w_href_lvl, w_href_rise, w_href_fall;
    logic w_vs_lvl,   w_vs_rise,   w_vs_fall;

    // Levels and edges this block does not act on.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_pclk_lvl, w_pclk_fall, w_href_rise, w_vs_lvl};

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
        .clk      (clk),
        .res      (res),
        .async_in (cam_pclk),
        .level    (w_pclk_lvl),
        .rise     (w_pclk_rise),
        .fall     (w_pclk_fall)
    );

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
        .clk      (clk),
        .res      (res),
        .async_in (cam_href),
        .level    (w_href_lvl),
        .rise     (w_href_rise),
        .fall     (w_href_fall)
    );

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
        .clk      (clk),
        .res      (res),
        .async_in (cam_vsync),
        .level    (w_vs_lvl),
        .rise     (w_vs_rise),
        .fall     (w_vs_fall)
    );

    // Registered state
    cam_state_t                         r_state;
    cam_state_t                         w_next;
    logic                               w_start;
    logic                               w_done;
    logic                               w_arm;

    logic [SYNC_STAGES-1:0][7:0]        r_data_sync;
    logic [7:0]                         r_data_align;
    logic [7:0]                         r_hi;
    logic                               r_phase;
    logic [c_x_w-1:0]                   r_x;
    logic [c_y_w-1:0]                   r_y;

    logic                               r_pix_valid;
    logic [15:0]                        r_pix_data;
    logic [c_x_w-1:0]                   r_pix_x;
    logic [c_y_w-1:0]                   r_pix_y;
    logic                               r_frame_start;
    logic                               r_frame_done;
    logic                               r_line_err;

    // Capture control: next state and frame strobes.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        w_arm   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A vs_fall in the same clk is ignored: the frame waits for the next one.
                if (capture) begin
                    w_next = ST_ARMED;
                    w_arm  = 1'b1;
                end
            end
            ST_ARMED: begin
                if (w_vs_fall) begin
                    w_next  = ST_ACTIVE;
                    w_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_vs_rise) begin
                    w_done = 1'b1;
`ifdef CAM_CONTINUOUS_EN
                    w_next = ST_ARMED;
`else
                    w_next = ST_IDLE;
`endif
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Byte pairing, coordinate tracking, pixel output and line error.
    always_ff @(posedge clk) begin
        if (res) begin
            r_data_sync   <= '0;
            r_data_align  <= '0;
            r_hi          <= '0;
            r_phase       <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_line_err    <= 1'b0;
        end else begin
            // The extra alignment register makes the byte used on a pclk_rise
            // the one sampled one clk after the pin-level rise, mid valid window.
            r_data_sync   <= {r_data_sync[SYNC_STAGES-2:0], cam_data};
            r_data_align  <= r_data_sync[SYNC_STAGES-1];
            r_pix_valid   <= 1'b0;
            r_frame_start <= w_start;
            r_frame_done  <= w_done;

            if (w_pclk_rise && w_href_lvl) begin
                if (!r_phase) begin
                    r_hi    <= r_data_align;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    if (r_state == ST_ACTIVE) begin
                        if ((r_x < c_h_lim) && (r_y < c_v_lim)) begin
                            r_pix_valid <= 1'b1;
                            r_pix_data  <= {r_hi, r_data_align};
                            r_pix_x     <= r_x;
                            r_pix_y     <= r_y;
                            r_x         <= r_x + {{(c_x_w-1){1'b0}}, 1'b1};
                        end else begin
                            r_line_err <= 1'b1;
                        end
                    end
                end
            end

            // End of line: a short, long or odd-length line is flagged.
            if (w_href_fall) begin
                r_phase <= 1'b0;
                if (r_state == ST_ACTIVE) begin
                    if ((r_x != c_h_lim) || r_phase) begin
                        r_line_err <= 1'b1;
                    end
                    r_x <= '0;
                    if (r_y != c_v_lim) begin
                        r_y <= r_y + {{(c_y_w-1){1'b0}}, 1'b1};
                    end
                end
            end

            if (w_start) begin
                r_x     <= '0;
                r_y     <= '0;
                r_phase <= 1'b0;
            end

            if (w_arm) begin
                r_line_err <= 1'b0;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign pix_valid   = r_pix_valid;
    assign pix_data    = r_pix_data;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign line_err    = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_cam_pixel_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_pixel_capture
//  Description : Self-checking bench for cam_pixel_capture. Drives OV-style
//                frames (pclk = 8 clk) with random line gaps and perturbed
//                lines, and compares against a frame/line/byte reference model.
//                Build option CAM_CONTINUOUS_EN selects the free-running test.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_pixel_capture;

    localparam int H   = 8;
    localparam int V   = 5;
    localparam int SS  = 2;
    localparam int LAT = SS + 2;
`ifdef CAM_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        res;
    logic        cam_pclk;
    logic        cam_href;
    logic        cam_vsync;
    logic [7:0]  cam_data;
    logic        capture;
    logic        busy;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        frame_start;
    logic        frame_done;
    logic        line_err;

    cam_pixel_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .res         (res),
        .cam_pclk    (cam_pclk),
        .cam_href    (cam_href),
        .cam_vsync   (cam_vsync),
        .cam_data    (cam_data),
        .capture     (capture),
        .busy        (busy),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .line_err    (line_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
        int          t;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int checks     = 0;
    int failures   = 0;
    int obs_starts = 0;
    int obs_dones  = 0;
    int obs_pix    = 0;
    int exp_starts = 0;
    int exp_dones  = 0;
    int exp_pix    = 0;
    bit exp_err    = 1'b0;
    bit exp_busy   = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: every pixel strobe must match the oldest expected pixel.
    always @(negedge clk) begin
        if (frame_start) obs_starts++;
        if (frame_done)  obs_dones++;
        if (pix_valid) begin
            obs_pix++;
            if (q.size() == 0) begin
                check_value("pix_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check_value("pix_data",    32'(pix_data), 32'(mon_e.d));
                check_value("pix_x",       32'(pix_x),    32'(mon_e.x));
                check_value("pix_y",       32'(pix_y),    32'(mon_e.y));
                check_value("pix_latency", 32'(cyc),      32'(mon_e.t));
            end
        end
    end

    // One pclk period: falling edge carries href and the new byte, rise 4 clk later.
    task automatic pclk_byte(input logic [7:0] b, input logic hv, output int rise_t);
        @(negedge clk);
        cam_pclk = 1'b0;
        cam_href = hv;
        cam_data = b;
        repeat (4) @(negedge clk);
        cam_pclk = 1'b1;
        rise_t   = cyc;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_line(input int nbytes, input bit hv, input bit live, input int y);
        int   t;
        int   p;
        int   gap;
        exp_t e;
        for (int k = 0; k < nbytes; k++) begin
            pclk_byte(8'(k), hv, t);
            if (hv && live && (k % 2 == 1)) begin
                p = k / 2;
                if (p < H && y < V) begin
                    e.d = {8'(k - 1), 8'(k)};
                    e.x = p;
                    e.y = y;
                    e.t = t + LAT;
                    q.push_back(e);
                    exp_pix++;
                end
            end
        end
        gap = $urandom_range(2, 5);
        for (int g = 0; g < gap; g++) pclk_byte(8'h00, 1'b0, t);
    endtask

    task automatic pulse_capture();
        @(negedge clk);
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        if (!exp_busy) begin
            exp_busy = 1'b1;
            exp_err  = 1'b0;
        end
        check_value("busy_after_capture", 32'(busy), 32'd1);
    endtask

    task automatic reset_and_check();
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        check_value("rst_busy",        32'(busy),        32'd0);
        check_value("rst_pix_valid",   32'(pix_valid),   32'd0);
        check_value("rst_pix_data",    32'(pix_data),    32'd0);
        check_value("rst_pix_x",       32'(pix_x),       32'd0);
        check_value("rst_pix_y",       32'(pix_y),       32'd0);
        check_value("rst_frame_start", 32'(frame_start), 32'd0);
        check_value("rst_frame_done",  32'(frame_done),  32'd0);
        check_value("rst_line_err",    32'(line_err),    32'd0);
        res      = 1'b0;
        exp_busy = 1'b0;
        exp_err  = 1'b0;
    endtask

    // One frame: vsync low (2 blank lines + active lines), then 3 vsync-high lines.
    task automatic run_frame(input bit armed, input int odd_ln, input int long_ln,
                             input int rst_ln, input bit extra_ln, input bit cap_at_fall,
                             input int busycap_ln);
        bit live;
        int nl;
        int n;
        live = armed;
        nl   = extra_ln ? V + 1 : V;
        @(negedge clk);
        cam_vsync = 1'b0;
        if (cap_at_fall) begin
            repeat (3) @(negedge clk);
            capture = 1'b1;
            @(negedge clk);
            capture  = 1'b0;
            exp_busy = 1'b1;
            exp_err  = 1'b0;
        end
        if (live) exp_starts++;
        for (int b = 0; b < 2; b++) send_line(2 * H, 1'b0, 1'b0, 0);
        for (int y = 0; y < nl; y++) begin
            n = 2 * H;
            if (y == odd_ln)  n = 2 * H - 1;
            if (y == long_ln) n = 2 * H + 2;
            if (live && (n != 2 * H || y >= V)) exp_err = 1'b1;
            send_line(n, 1'b1, live, y);
            check_value("busy_in_frame", 32'(busy), 32'(exp_busy));
            if (y == busycap_ln) pulse_capture();
            if (y == rst_ln) begin
                reset_and_check();
                live = 1'b0;
                pulse_capture();
            end
        end
        @(negedge clk);
        cam_vsync = 1'b1;
        if (live) begin
            exp_dones++;
            exp_busy = CONT;
        end
        for (int b = 0; b < 3; b++) send_line(2 * H, 1'b0, 1'b0, 0);
        check_value("frame_starts", 32'(obs_starts), 32'(exp_starts));
        check_value("frame_dones",  32'(obs_dones),  32'(exp_dones));
        check_value("pix_count",    32'(obs_pix),    32'(exp_pix));
        check_value("pix_missing",  32'(q.size()),   32'd0);
        check_value("line_err",     32'(line_err),   32'(exp_err));
        check_value("busy_end",     32'(busy),       32'(exp_busy));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        res       = 1'b1;
        cam_pclk  = 1'b0;
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        cam_data  = 8'h00;
        capture   = 1'b0;
        repeat (3) @(negedge clk);
        reset_and_check();
        for (int b = 0; b < 3; b++) send_line(2 * H, 1'b0, 1'b0, 0);

`ifdef CAM_CONTINUOUS_EN
        // One capture, two frames back to back.
        pulse_capture();
        run_frame(1'b1, -1, -1, -1, 1'b0, 1'b0, -1);
        run_frame(1'b1, -1, -1, -1, 1'b0, 1'b0, -1);
        check_value("cont_two_dones", 32'(obs_dones), 32'd2);
`else
        // Clean armed frame.
        pulse_capture();
        run_frame(1'b1, -1, -1, -1, 1'b0, 1'b0, -1);
        // No capture: nothing happens.
        run_frame(1'b0, -1, -1, -1, 1'b0, 1'b0, -1);
        // Odd line somewhere, then a capture while busy that must not clear line_err.
        pulse_capture();
        check_value("err_cleared_on_arm", 32'(line_err), 32'd0);
        run_frame(1'b1, int'($urandom_range(0, V - 2)), -1, -1, 1'b0, 1'b0, V - 1);
        // Over-long line plus a line beyond V_ACTIVE.
        pulse_capture();
        check_value("err_cleared_on_arm", 32'(line_err), 32'd0);
        run_frame(1'b1, -1, int'($urandom_range(0, V - 1)), -1, 1'b1, 1'b0, -1);
        // Reset mid-frame, re-arm while vsync is low.
        pulse_capture();
        run_frame(1'b1, -1, -1, int'($urandom_range(1, V - 2)), 1'b0, 1'b0, -1);
        // Re-armed frame is clean.
        run_frame(1'b1, -1, -1, -1, 1'b0, 1'b0, -1);
        // Capture coincident with vs_fall: arm only.
        run_frame(1'b0, -1, -1, -1, 1'b0, 1'b1, -1);
        run_frame(1'b1, -1, -1, -1, 1'b0, 1'b0, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Front-end capture stage inside balldetector, directly consuming the OV-style camera pins: pclk, href, vsync and 8-bit data.
- Synchronises the camera signals into the clk domain and assembles byte pairs into 16-bit pixels.
- Tags each pixel with x/y coordinates and frames it with start/done strobes for the downstream colour-threshold/centroid logic.

Parameters:
- H_ACTIVE, 640, pixels per line (2 bytes each).
- V_ACTIVE, 480, lines per frame.
- SYNC_STAGES, 2, flop stages on each camera input (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x pclk.
- res  in  1  synchronous active-high reset.
- cam_pclk  in  1  camera pixel clock; async to clk.
- cam_href  in  1  line-valid, high during active bytes.
- cam_vsync  in  1  frame sync, high during vertical blanking.
- cam_data  in  8  camera byte; changes on pclk falling edge.
- capture  in  1  one-clk pulse that arms capture of the next frame.
- busy  out  1  high from arm until frame_done.
- pix_valid  out  1  one-clk strobe: pix_data/pix_x/pix_y are valid.
- pix_data  out  16  {first byte, second byte}.
- pix_x  out  10  0..H_ACTIVE-1.
- pix_y  out  9  0..V_ACTIVE-1.
- frame_start  out  1  one-clk strobe at the start of an armed frame.
- frame_done  out  1  one-clk strobe at the end of the frame.
- line_err  out  1  sticky; cleared on arm or reset.

Behaviour:
- Clock/reset: single clock domain clk; reset res is synchronous and active-high.
- Synchronisers: cam_pclk, cam_href, cam_vsync and cam_data each pass through SYNC_STAGES flops. Event signals:
  - pclk_rise = sync pclk 0->1.
  - href_fall = sync href 1->0.
  - vs_fall / vs_rise = sync vsync edges.
- Data sampling: bytes are sampled on pclk_rise only while sync href = 1.
- Byte phase: phase toggles per sampled byte and is cleared on every href_fall.
  - phase 0: byte held in hi_reg.
  - phase 1: pixel emitted.
- Latency: pix_valid is exactly SYNC_STAGES+2 clk after the pin-level pclk rise of the second byte (4 clk at default).
- FSM:
  - IDLE: busy=0. capture -> ARMED.
  - ARMED: busy=1. vs_fall -> ACTIVE, pulse frame_start, x=0, y=0.
  - ACTIVE: emit pixels; x increments after each emitted pixel.
    - href_fall: if x != H_ACTIVE or phase==1, set line_err; then x=0, y++ (saturates at V_ACTIVE).
    - vs_rise -> IDLE, pulse frame_done.
- Boundaries:
  - Pixels with x >= H_ACTIVE or y >= V_ACTIVE are dropped (no pix_valid) and set line_err.
  - A partial pixel (odd byte count) at href_fall is discarded and sets line_err.
  - vs_rise mid-line: frame_done still pulses; the partial line is not flagged.
  - capture while busy: ignored.
  - capture in the same clk as vs_fall: arm only; the frame starts at the next vs_fall.
  - Arming in mid-frame (vsync low): wait in ARMED for the following vs_fall.
- Reset values: all outputs 0, state IDLE, counters 0, sync flops 0. Reset mid-frame aborts with no frame_done.

Optional Feature:
- Macro: CAM_CONTINUOUS_EN.
- Defined: after frame_done the FSM goes to ARMED instead of IDLE, so capture free-runs. busy stays 1 after the first capture until res.
- Undefined: single-shot; each frame requires a new capture pulse.

Decomposition:
- Package cam_pkg: H_ACTIVE/V_ACTIVE defaults, coordinate widths, FSM state encoding (IDLE, ARMED, ACTIVE).
- Sub-module cam_sync_edge: generic SYNC_STAGES synchroniser with rise/fall outputs, instantiated for pclk, href and vsync.

Test Plan:
- Stimulus: pclk period 8x clk; 3 lines vsync high, 17 lines blank, 480 lines of 1280 bytes, byte k of each line = k mod 256; capture pulsed before the vsync fall.
- Full frame -> frame_start once; exactly 307200 pix_valid; first pixel x=0 y=0 data 0x0001; last pixel x=639 y=479 data 0xFEFF; frame_done once; line_err=0.
- No capture pulse -> zero pix_valid, busy=0 for the whole frame.
- One line truncated to 1279 bytes (odd) -> 639 pixels on that line, line_err=1, next line y increments and starts at x=0.
- One line of 1282 bytes -> 641st pixel dropped, line_err=1.
- res asserted at line 200 -> all outputs 0 the next clk, no frame_done. Re-arm -> the next full frame is clean.
- CAM_CONTINUOUS_EN defined, two frames, one capture -> two frame_start/frame_done pairs; busy remains 1.
